avalon_pipelined_ram_responder: RTL and testbench



---
 rtl/avalon_pipelined_ram_responder.sv | 94 +++++++++
 tb/tb_avalon_pipelined_ram_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pipelined_ram_responder.sv
// Avalon-MM pipelined slave backed by an internal 32-bit RAM: byte-enable writes,
// fixed-latency in-order reads, and an outstanding-read limit enforced through waitrequest.
module avalon_pipelined_ram_responder #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        byteenable,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              endofpacket,
  output logic              waitrequest
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int LAT    = READ_LATENCY;

  // Valid/ready: a request transfers on a rising edge where it is high and waitrequest
  // is low; with read and write both high only the write transfers.
  logic              read_accept;
  logic              write_accept;
  logic [PEND_W-1:0] pending;
  logic [31:0]       mem [DEPTH];

  logic [LAT-1:0]    stage_valid;
  logic [LAT-1:0]    stage_eop;
  logic [31:0]       stage_data [LAT];
  logic [LAT-1:0]    in_valid;
  logic [LAT-1:0]    in_eop;
  logic [31:0]       in_data [LAT];

  assign waitrequest  = (pending == PEND_W'(MAX_PENDING));
  assign write_accept = write & ~waitrequest;
  assign read_accept  = read & ~write & ~waitrequest;

  always_ff @(posedge clk) begin
    if (write_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Stage 0 captures the RAM word at the accept edge, so later writes never touch in-flight data.
  always_comb begin
    in_valid[0] = read_accept;
    in_data[0]  = mem[address];
    in_eop[0]   = &address;
    for (int i = 1; i < LAT; i++) begin
      in_valid[i] = stage_valid[i-1];
      in_data[i]  = stage_data[i-1];
      in_eop[i]   = stage_eop[i-1];
    end
  end

  // Data only loads behind a valid, so the last stage holds its word between pulses;
  // only valids and the output stage are cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid         <= '0;
      stage_data[LAT-1]   <= '0;
      stage_eop[LAT-1]    <= 1'b0;
    end else begin
      stage_valid <= in_valid;
      for (int i = 0; i < LAT; i++) begin
        if (in_valid[i]) begin
          stage_data[i] <= in_data[i];
          stage_eop[i]  <= in_eop[i];
        end
      end
    end
  end

  assign readdatavalid = stage_valid[LAT-1];
  assign readdata      = stage_data[LAT-1];
  assign endofpacket   = stage_valid[LAT-1] & stage_eop[LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (read_accept && !readdatavalid) begin
      pending <= pending + PEND_W'(1);
    end else if (!read_accept && readdatavalid) begin
      pending <= pending - PEND_W'(1);
    end
  end

endmodule

// File: tb/tb_avalon_pipelined_ram_responder.sv
// Bench for avalon_pipelined_ram_responder: two instances (MAX_PENDING 4 and 2) checked
// every cycle against a transaction-level model of memory, read returns and outstanding count.
module tb_avalon_pipelined_ram_responder;
  localparam int L = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sel;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] rd_a, rd_b;
  logic        rdv_a, rdv_b, eop_a, eop_b, wr_a, wr_b;

  avalon_pipelined_ram_responder #(.ADDR_W(8), .READ_LATENCY(3), .MAX_PENDING(4)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .read(read & ~sel), .write(write & ~sel), .writedata(writedata),
    .readdata(rd_a), .readdatavalid(rdv_a), .endofpacket(eop_a), .waitrequest(wr_a)
  );

  avalon_pipelined_ram_responder #(.ADDR_W(8), .READ_LATENCY(3), .MAX_PENDING(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .read(read & sel), .write(write & sel), .writedata(writedata),
    .readdata(rd_b), .readdatavalid(rdv_b), .endofpacket(eop_b), .waitrequest(wr_b)
  );

  logic [31:0] obs_d;
  logic        obs_v, obs_e, obs_w;
  assign obs_d = sel ? rd_b  : rd_a;
  assign obs_v = sel ? rdv_b : rdv_a;
  assign obs_e = sel ? eop_b : eop_a;
  assign obs_w = sel ? wr_b  : wr_a;

  // reference model: per-instance memory image, accepted-read queue with due edges
  logic [31:0] ref_mem [2][256];
  logic [31:0] hold_data [2];
  int          acc_q[$];
  logic [31:0] exp_q[$];
  logic        eop_q[$];
  int          due_q[$];
  int          edge_n = 0;
  bit          last_acc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edge_n);
    end
  endtask

  // one clock: model the accept at the coming edge, then compare outputs at the falling edge
  task automatic step();
    int          mp    = sel ? 2 : 4;
    bit          stall = (acc_q.size() >= mp);
    bit          exp_v;
    logic        e;
    @(posedge clk);
    edge_n++;
    last_acc = 1'b0;
    while (acc_q.size() > 0 && acc_q[0] + L <= edge_n) void'(acc_q.pop_front());
    if (reset_n && !stall) begin
      if (write) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) ref_mem[sel][address][8*b +: 8] = writedata[8*b +: 8];
      end else if (read) begin
        acc_q.push_back(edge_n);
        exp_q.push_back(ref_mem[sel][address]);
        eop_q.push_back(address == 8'hFF);
        due_q.push_back(edge_n + L - 1);
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
    exp_v = (due_q.size() > 0 && due_q[0] == edge_n);
    check("readdatavalid", 32'(obs_v), 32'(exp_v));
    e = 1'b0;
    if (exp_v) begin
      hold_data[sel] = exp_q.pop_front();
      e = eop_q.pop_front();
      void'(due_q.pop_front());
    end
    check("readdata", obs_d, hold_data[sel]);
    check("endofpacket", 32'(obs_e), 32'(e));
    check("waitrequest", 32'(obs_w), 32'(acc_q.size() >= mp));
  endtask

  // driver tasks
  task automatic drive(input bit s, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    sel = s; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(sel, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
  endtask

  task automatic apply_reset(input int cycles);
    read = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    acc_q.delete(); exp_q.delete(); eop_q.delete(); due_q.delete();
    hold_data[0] = '0; hold_data[1] = '0;
    #1;
    check("rst_rdv_a", 32'(rdv_a), 32'd0);
    check("rst_wait_a", 32'(wr_a), 32'd0);
    check("rst_data_a", rd_a, 32'd0);
    check("rst_eop_a", 32'(eop_a), 32'd0);
    check("rst_rdv_b", 32'(rdv_b), 32'd0);
    check("rst_wait_b", 32'(wr_b), 32'd0);
    check("rst_data_b", rd_b, 32'd0);
    check("rst_eop_b", 32'(eop_b), 32'd0);
    repeat (cycles) step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; sel = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    #2;
    apply_reset(3);

    // preload both RAMs; words 0..7 hold their own address
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 256; a++)
        drive(s[0], 1'b0, 1'b1, 8'(a), 4'hF, (a < 8) ? 32'(a) : $urandom);
      idle(2);
    end
    sel = 1'b0;
    idle(2);

    // byte-lane merge and three-cycle read latency
    drive(1'b0, 1'b0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 4'b0001, 32'h000000AA);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    idle(2);
    check("t2_data", obs_d, 32'hDEADBEAA);
    check("t2_valid", 32'(obs_v), 32'd1);
    check("t2_eop", 32'(obs_e), 32'd0);
    idle(3);

    // eight back-to-back reads, no stall expected
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 8'(i), 4'h0, 32'h0);
    idle(5);

    // end-of-packet on the top address only
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'hFE, 4'h0, 32'h0);
    idle(5);

    // write-then-read, read-then-write, and both-high treated as write
    drive(1'b0, 1'b0, 1'b1, 8'h20, 4'hF, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 8'h20, 4'hF, 32'h2);
    idle(1);
    check("t6_first", obs_d, 32'h1);
    idle(4);
    drive(1'b0, 1'b1, 1'b1, 8'h21, 4'hF, 32'h5A5A0021);
    drive(1'b0, 1'b0, 1'b1, 8'h22, 4'h0, 32'hFFFFFFFF);
    idle(4);
    drive(1'b0, 1'b1, 1'b0, 8'h21, 4'h0, 32'h0);
    idle(5);

    // MAX_PENDING=2 instance: reads held until accepted through waitrequest stalls
    sel = 1'b1;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      int tries = 0;
      do begin
        drive(1'b1, 1'b1, 1'b0, 8'(i), 4'h0, 32'h0);
        tries++;
      end while (!last_acc && tries < 10);
    end
    idle(6);

    // randomized traffic on each instance
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      idle(1);
      repeat (300)
        drive(s[0], $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
              8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom);
      idle(6);
    end

    // reset in the middle of a burst discards in-flight reads; RAM survives
    sel = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 4'h0, 32'h0);
    apply_reset(2);
    idle(6);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
